dm_arbiter: RTL

- Shares one single-port data memory between NUM_CORES processor cores of the multi-core multiplier.
- Each core issues a read or write request; the block grants one request per cycle using round-robin priority and drives the registered memory command.
- Read data returns to the issuing core with a per-core valid strobe.
- Optional bus lock keeps read-modify-write sequences atomic; sits between the core array and the shared DM.

---
 rtl/dm_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_CORES cores,
// with a registered memory command and an optional bus lock for atomic RMW sequences.
module dm_arbiter #(
  parameter  int NUM_CORES = 4,
  parameter  int ADDR_W    = 16,
  parameter  int DATA_W    = 8,
  localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        wr,
  input  logic [NUM_CORES-1:0]        lock,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        locked,
  output logic [IDX_W-1:0]            lock_owner
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t      state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] owner_nxt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [IDX_W-1:0] core_p1;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return s[IDX_W-1:0];
  endfunction

  // Stage p0: pick one requester; while locked only the owner is eligible
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (rst_n) begin
      if (state == LOCKED) begin
        if (req[lock_owner]) begin
          gnt_any = 1'b1;
          gnt_idx = lock_owner;
        end
      end else begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (!gnt_any && req[wrap_add(ptr, i)]) begin
            gnt_any = 1'b1;
            gnt_idx = wrap_add(ptr, i);
          end
        end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = lock_owner;
    ptr_nxt   = ptr;
    case (state)
      UNLOCKED: begin
        if (gnt_any) begin
          ptr_nxt = wrap_add(gnt_idx, 1);
          if (lock[gnt_idx]) begin
            state_nxt = LOCKED;
            owner_nxt = gnt_idx;
          end
        end
      end
      LOCKED: begin
        // Pointer is frozen while the lock is held; the unlocking access advances it
        if (gnt_any && !lock[gnt_idx]) begin
          state_nxt = UNLOCKED;
          owner_nxt = '0;
          ptr_nxt   = wrap_add(gnt_idx, 1);
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      lock_owner <= '0;
      ptr        <= '0;
    end else begin
      state      <= state_nxt;
      lock_owner <= owner_nxt;
      ptr        <= ptr_nxt;
    end
  end

  assign locked = (state == LOCKED);

  // Stage p1: registered memory command from the accepted core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= gnt_any;
      mem_we <= gnt_any & wr[gnt_idx];
      if (gnt_any) begin
        mem_addr  <= addr[gnt_idx*ADDR_W +: ADDR_W];
        mem_wdata <= wdata[gnt_idx*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_any) core_p1 <= gnt_idx;
  end

  // Stage p2: read-data strobe back to the issuing core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
    end else begin
      rvalid <= '0;
      if (mem_en && !mem_we) rvalid[core_p1] <= 1'b1;
    end
  end

  assign rdata = mem_rdata;

endmodule
